// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencer and owner of the two-digit BCD count.
// It turns button pulses and the one-second tick into count updates and
// divider enable/restart controls. Every output comes straight from a flop.
//
// Handshake note: this block has no valid/ready channels. Each input is a
// single-cycle pulse. It is sampled on one rising edge, and its effect is
// visible on the registered outputs in the following cycle.
module stopwatch_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_start,
    input  logic       ten_start,
    input  logic       pause,
    input  logic       clr,
    input  logic       second_tick,
    output logic [7:0] number,
    output logic       running,
    output logic       paused,
    output logic       mode_ten,
    output logic       timer_en,
    output logic       timer_restart,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_ONE = 2'd1,
        RUN_TEN = 2'd2,
        PAUSED  = 2'd3
    } state_t;

    // Current FSM state, kept as a named enum so checkers can bind to it.
    state_t state;

    logic [3:0] ones;
    logic [3:0] tens;
    logic [7:0] inc_number;
    logic       inc_wrap;
    logic       count_en;

    assign ones = number[3:0];
    assign tens = number[7:4];

    // The step size follows the state that is current when the tick arrives.
    // A mode-switch pulse in the same cycle only affects later ticks.
    assign count_en = second_tick && ((state == RUN_ONE) || (state == RUN_TEN));

    // BCD increment: +1 carries from ones into tens; +10 touches only tens.
    always_comb begin
        inc_number = number;
        inc_wrap   = 1'b0;
        if (state == RUN_TEN) begin
            if (tens < 4'd9) begin
                inc_number[7:4] = tens + 4'd1;
            end else begin
                inc_number[7:4] = 4'd0;
                inc_wrap        = 1'b1;
            end
        end else begin
            if (ones < 4'd9) begin
                inc_number[3:0] = ones + 4'd1;
            end else begin
                inc_number[3:0] = 4'd0;
                if (tens < 4'd9) begin
                    inc_number[7:4] = tens + 4'd1;
                end else begin
                    inc_number[7:4] = 4'd0;
                    inc_wrap        = 1'b1;
                end
            end
        end
    end

    // Sequencer, count register and all registered outputs.
    // Pulse priority is clr > pause > ten_start > one_start. The highest pulse
    // present decides the transition, even in a state that ignores it
    // (pause in IDLE masks a simultaneous start).
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            number        <= 8'h00;
            running       <= 1'b0;
            paused        <= 1'b0;
            mode_ten      <= 1'b0;
            timer_en      <= 1'b0;
            timer_restart <= 1'b0;
            wrap          <= 1'b0;
        end else if (clr) begin
            // Clear drops any tick in the same cycle.
            state         <= IDLE;
            number        <= 8'h00;
            running       <= 1'b0;
            paused        <= 1'b0;
            mode_ten      <= 1'b0;
            timer_en      <= 1'b0;
            timer_restart <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            timer_restart <= 1'b0;
            wrap          <= 1'b0;

            if (count_en) begin
                number <= inc_number;
                wrap   <= inc_wrap;
            end

            case (state)
                IDLE: begin
                    if (pause) begin
                        state <= IDLE;
                    end else if (ten_start) begin
                        state         <= RUN_TEN;
                        mode_ten      <= 1'b1;
                        running       <= 1'b1;
                        timer_en      <= 1'b1;
                        timer_restart <= 1'b1;
                    end else if (one_start) begin
                        state         <= RUN_ONE;
                        mode_ten      <= 1'b0;
                        running       <= 1'b1;
                        timer_en      <= 1'b1;
                        timer_restart <= 1'b1;
                    end
                end

                RUN_ONE: begin
                    if (pause) begin
                        state    <= PAUSED;
                        running  <= 1'b0;
                        timer_en <= 1'b0;
                        paused   <= 1'b1;
                    end else if (ten_start) begin
                        // Mode switch while running keeps the divider phase.
                        state    <= RUN_TEN;
                        mode_ten <= 1'b1;
                    end
                end

                RUN_TEN: begin
                    if (pause) begin
                        state    <= PAUSED;
                        running  <= 1'b0;
                        timer_en <= 1'b0;
                        paused   <= 1'b1;
                    end else if (ten_start) begin
                        state <= RUN_TEN;
                    end else if (one_start) begin
                        state    <= RUN_ONE;
                        mode_ten <= 1'b0;
                    end
                end

                PAUSED: begin
                    if (pause) begin
                        // Resume in the saved mode.
                        state         <= mode_ten ? RUN_TEN : RUN_ONE;
                        paused        <= 1'b0;
                        running       <= 1'b1;
                        timer_en      <= 1'b1;
                        timer_restart <= 1'b1;
                    end else if (ten_start) begin
                        state         <= RUN_TEN;
                        mode_ten      <= 1'b1;
                        paused        <= 1'b0;
                        running       <= 1'b1;
                        timer_en      <= 1'b1;
                        timer_restart <= 1'b1;
                    end else if (one_start) begin
                        state         <= RUN_ONE;
                        mode_ten      <= 1'b0;
                        paused        <= 1'b0;
                        running       <= 1'b1;
                        timer_en      <= 1'b1;
                        timer_restart <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Structural invariants: BCD digits in range, flags consistent with state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (number[3:0] <= 4'd9);
            assert (number[7:4] <= 4'd9);
            assert (timer_en == running);
            assert (!(running && paused));
            assert (running == ((state == RUN_ONE) || (state == RUN_TEN)));
            assert (paused == (state == PAUSED));
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed vectors with a decimal reference
// model, a per-cycle expected queue and a decoupled monitor.
module tb_stopwatch_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       one_start = 1'b0;
    logic       ten_start = 1'b0;
    logic       pause = 1'b0;
    logic       clr = 1'b0;
    logic       second_tick = 1'b0;
    logic [7:0] number;
    logic       running;
    logic       paused;
    logic       mode_ten;
    logic       timer_en;
    logic       timer_restart;
    logic       wrap;

    stopwatch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .one_start     (one_start),
        .ten_start     (ten_start),
        .pause         (pause),
        .clr           (clr),
        .second_tick   (second_tick),
        .number        (number),
        .running       (running),
        .paused        (paused),
        .mode_ten      (mode_ten),
        .timer_en      (timer_en),
        .timer_restart (timer_restart),
        .wrap          (wrap)
    );

    // ---------------- reference model ----------------
    localparam int S_IDLE = 0, S_RO = 1, S_RT = 2, S_P = 3;
    int   m_state = S_IDLE;
    int   m_num   = 0;
    logic m_mode  = 1'b0;
    logic m_restart = 1'b0;
    logic m_wrap  = 1'b0;

    int checks   = 0;
    int failures = 0;
    int wrap_seen = 0;

    // {number, running, paused, mode_ten, timer_en, timer_restart, wrap}
    logic [13:0] exp_q[$];

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic logic [13:0] model_vec();
        logic run;
        run = (m_state == S_RO) || (m_state == S_RT);
        return {to_bcd(m_num), run, (m_state == S_P), m_mode, run, m_restart, m_wrap};
    endfunction

    task automatic model_step(input logic r, input logic o, input logic t,
                              input logic p, input logic c, input logic k);
        int td;
        m_restart = 1'b0;
        m_wrap    = 1'b0;
        if (r || c) begin
            m_state = S_IDLE;
            m_num   = 0;
            m_mode  = 1'b0;
        end else begin
            if (k && (m_state == S_RO || m_state == S_RT)) begin
                if (m_state == S_RT) begin
                    td = m_num / 10;
                    if (td == 9) begin td = 0; m_wrap = 1'b1; end
                    else td = td + 1;
                    m_num = td * 10 + (m_num % 10);
                end else begin
                    if (m_num == 99) begin m_num = 0; m_wrap = 1'b1; end
                    else m_num = m_num + 1;
                end
            end
            case (m_state)
                S_IDLE: if (!p) begin
                    if (t) begin m_state = S_RT; m_mode = 1'b1; m_restart = 1'b1; end
                    else if (o) begin m_state = S_RO; m_mode = 1'b0; m_restart = 1'b1; end
                end
                S_RO: if (p) m_state = S_P;
                      else if (t) begin m_state = S_RT; m_mode = 1'b1; end
                S_RT: if (p) m_state = S_P;
                      else if (!t && o) begin m_state = S_RO; m_mode = 1'b0; end
                default: begin
                    if (p) begin m_state = m_mode ? S_RT : S_RO; m_restart = 1'b1; end
                    else if (t) begin m_state = S_RT; m_mode = 1'b1; m_restart = 1'b1; end
                    else if (o) begin m_state = S_RO; m_mode = 1'b0; m_restart = 1'b1; end
                end
            endcase
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle of inputs at the falling edge and queue the expected
    // outputs for the following rising edge.
    task automatic drive(input logic r, input logic o, input logic t,
                         input logic p, input logic c, input logic k);
        @(negedge clk);
        rst = r; one_start = o; ten_start = t; pause = p; clr = c; second_tick = k;
        model_step(r, o, t, p, c, k);
        exp_q.push_back(model_vec());
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Hand-computed checkpoint on the value produced by the last driven cycle.
    task automatic checkpoint(input string name, input logic [7:0] exp_num,
                              input logic exp_run, input logic exp_pau, input logic exp_mode);
        @(posedge clk);
        #2;
        checks++;
        if (number !== exp_num || running !== exp_run || paused !== exp_pau || mode_ten !== exp_mode) begin
            failures++;
            $display("FAIL %s: got num=%02h run=%0b pau=%0b mode=%0b, want num=%02h run=%0b pau=%0b mode=%0b",
                     name, number, running, paused, mode_ten, exp_num, exp_run, exp_pau, exp_mode);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            logic [13:0] a;
            e = exp_q.pop_front();
            a = {number, running, paused, mode_ten, timer_en, timer_restart, wrap};
            if (wrap === 1'b1) wrap_seen++;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_outputs @%0t: got num=%02h run=%0b pau=%0b mode=%0b en=%0b rst=%0b wrap=%0b, want num=%02h run=%0b pau=%0b mode=%0b en=%0b rst=%0b wrap=%0b",
                         $time, a[13:6], a[5], a[4], a[3], a[2], a[1], a[0],
                         e[13:6], e[5], e[4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        // Reset then idle ticks.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkpoint("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
        ticks(5);
        checkpoint("idle_ticks", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // pause ignored in IDLE
        checkpoint("idle_pause", 8'h00, 1'b0, 1'b0, 1'b0);

        // Ones run, 100 ticks, one wrap.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkpoint("one_start", 8'h00, 1'b1, 1'b0, 1'b0);
        ticks(98);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkpoint("ones_99", 8'h99, 1'b1, 1'b0, 1'b0);
        w0 = wrap_seen;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkpoint("ones_wrap_00", 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (wrap_seen - w0 != 1) begin
            failures++;
            $display("FAIL ones_wrap_count: got %0d, want 1", wrap_seen - w0);
        end

        // Tens run and mode switches.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkpoint("clear", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        checkpoint("tens_30", 8'h30, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(2);
        checkpoint("ones_32", 8'h32, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(7);
        checkpoint("tens_wrap_02", 8'h02, 1'b1, 1'b0, 1'b1);
        // Mode-switch pulse coincident with a tick: step uses the old mode.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkpoint("switch_with_tick", 8'h12, 1'b1, 1'b0, 1'b0);

        // Pause/resume keeps the tens mode.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2);
        checkpoint("tens_20", 8'h20, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        checkpoint("paused_hold", 8'h20, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        checkpoint("resume_30", 8'h30, 1'b1, 1'b0, 1'b1);
        // Back-to-back pause pulses: PAUSED then RUN.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkpoint("pause_pause", 8'h30, 1'b1, 1'b0, 1'b1);
        // Start pulse from PAUSED switches mode and restarts.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(1);
        checkpoint("paused_one_start", 8'h31, 1'b1, 1'b0, 1'b0);

        // Simultaneous events at 0x45.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(5);
        checkpoint("reach_45", 8'h45, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkpoint("clr_tick_pause", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(5);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkpoint("pause_tick_46", 8'h46, 1'b0, 1'b1, 1'b0);

        // Reset mid-run with a tick.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(7);
        checkpoint("tens_70", 8'h70, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkpoint("rst_mid_run", 8'h00, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        idle_cycle();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
